// File: rtl/imm_pkg.sv
// Shared definitions for the instruction packer: opcodes, FSM states,
// immediate range limits and the packed-word field layout.
package imm_pkg;

  localparam logic [4:0] OP_IMM10A = 5'b11000;
  localparam logic [4:0] OP_IMM10B = 5'b10010;
  localparam logic [4:0] OP_IMM17  = 5'b01000;
  localparam logic [4:0] OP_IMM15  = 5'b00100;

  localparam int IMM10_MIN = 0;
  localparam int IMM10_MAX = 1023;
  localparam int IMM17_MIN = -65536;
  localparam int IMM17_MAX = 65535;
  localparam int IMM15_MIN = -16384;
  localparam int IMM15_MAX = 16383;

  localparam int OPC_W  = 5;
  localparam int IMM_W  = 32;
  localparam int P1_W   = 15;
  localparam int AUX_W  = 2;
  localparam int P2_W   = 10;
  localparam int WORD_W = OPC_W + P1_W + AUX_W + P2_W;

  // Immediate bit positions (index 0 = MSB) feeding each field.
  localparam int IMM_P2_POS  = 22;
  localparam int IMM17_POS   = 15;
  localparam int IMM17_HI_W  = 7;
  localparam int IMM15_POS   = 17;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} imm_state_e;

  function automatic logic [0:WORD_W-1] pack_word(
    input logic [0:OPC_W-1] op,
    input logic [0:P1_W-1]  p1,
    input logic [0:AUX_W-1] aux,
    input logic [0:P2_W-1]  p2
  );
    return {op, p1, aux, p2};
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational per-opcode immediate splitter: produces the P1/P2 fields
// and flags whether the immediate fits the opcode's range.
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [0:OPC_W-1] opcode,
  input  logic [0:IMM_W-1] imm,
  input  logic [0:P1_W-1]  p1_raw,
  input  logic [0:P2_W-1]  p2_raw,
  output logic [0:P1_W-1]  p1,
  output logic [0:P2_W-1]  p2,
  output logic             range_ok
);

  logic signed [IMM_W-1:0] imm_s;
  assign imm_s = imm;

  always_comb begin
    p1       = p1_raw;
    p2       = p2_raw;
    range_ok = 1'b1;
    case (opcode)
      OP_IMM10A, OP_IMM10B: begin
        p2       = imm[IMM_P2_POS +: P2_W];
        range_ok = (imm_s >= IMM10_MIN) && (imm_s <= IMM10_MAX);
      end
      OP_IMM17: begin
        // Upper 7 immediate bits take over the top of P1; the rest of P1 stays raw.
        p1       = {imm[IMM17_POS +: IMM17_HI_W], p1_raw[IMM17_HI_W:P1_W-1]};
        p2       = imm[IMM_P2_POS +: P2_W];
        range_ok = (imm_s >= IMM17_MIN) && (imm_s <= IMM17_MAX);
      end
      OP_IMM15: begin
        p1       = imm[IMM15_POS +: P1_W];
        range_ok = (imm_s >= IMM15_MIN) && (imm_s <= IMM15_MAX);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Burst instruction packer: accepts opcode/immediate tuples, packs them and
// writes them to consecutive instruction-memory addresses.
module imm_encoder
  import imm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W:0]    num_instr,
  // Handshakes: a beat transfers on a rising edge where valid and ready are
  // both high; a source holds its payload stable until then.
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:OPC_W-1]   in_opcode,
  input  logic [0:IMM_W-1]   in_imm,
  input  logic [0:P1_W-1]    in_p1_raw,
  input  logic [0:P2_W-1]    in_p2_raw,
  input  logic [0:AUX_W-1]   in_aux,
  output logic               mem_we,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [0:WORD_W-1]  mem_wdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [ADDR_W-1:0]  err_addr,
  output imm_state_e         dbg_state
);

  imm_state_e          state, next_state;
  logic [ADDR_W:0]     remaining;
  logic [0:P1_W-1]     p1;
  logic [0:P2_W-1]     p2;
  logic                range_ok;
  logic                accept, mem_fire, start_ok;
  logic [ADDR_W-1:0]   word_addr;

  imm_field_pack u_pack (
    .opcode   (in_opcode),
    .imm      (in_imm),
    .p1_raw   (in_p1_raw),
    .p2_raw   (in_p2_raw),
    .p1       (p1),
    .p2       (p2),
    .range_ok (range_ok)
  );

  assign in_ready  = (state == RUN) && (remaining != '0) && (!mem_we || mem_ready);
  assign accept    = in_valid && in_ready;
  assign mem_fire  = mem_we && mem_ready;
  assign start_ok  = start && (state == IDLE);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign done      = (state == DONE);
  assign dbg_state = state;
  // A word accepted while the previous one retires lands one address later.
  assign word_addr = mem_fire ? mem_addr + ADDR_W'(1) : mem_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (num_instr != '0) ? RUN : DONE;
      RUN:     if ((remaining == '0) || (accept && remaining == (ADDR_W+1)'(1)))
                 next_state = DRAIN;
      DRAIN:   if (!mem_we || mem_ready) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
    end else begin
      if (start_ok) begin
        remaining <= num_instr;
        mem_addr  <= base_addr;
        err       <= 1'b0;
        err_addr  <= '0;
      end else begin
        if (mem_fire) mem_addr <= mem_addr + ADDR_W'(1);
        if (accept) begin
          remaining <= remaining - (ADDR_W+1)'(1);
          if (!range_ok) begin
            err <= 1'b1;
            if (!err) err_addr <= word_addr;
          end
        end
      end
      if (accept) begin
        mem_we    <= 1'b1;
        mem_wdata <= range_ok ? pack_word(in_opcode, p1, in_aux, p2) : '0;
      end else if (mem_fire) begin
        mem_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: burst writes, range errors, stalls,
// address wrap, reset abort and empty bursts.
module tb_imm_encoder;
  import imm_pkg::*;

  localparam int ADDR_W = 10;
  localparam int EW     = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   num_instr = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [0:4]        in_opcode = '0;
  logic [0:31]       in_imm = '0;
  logic [0:14]       in_p1_raw = '0;
  logic [0:9]        in_p2_raw = '0;
  logic [0:1]        in_aux = '0;
  logic              mem_we;
  logic              mem_ready = 1'b1;
  logic [ADDR_W-1:0] mem_addr;
  logic [0:31]       mem_wdata;
  logic              busy, done, err;
  logic [ADDR_W-1:0] err_addr;
  imm_state_e        dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_wr_cyc = 0;
  int last_done_cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_q[$];

  imm_encoder #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_instr(num_instr), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_imm(in_imm), .in_p1_raw(in_p1_raw),
    .in_p2_raw(in_p2_raw), .in_aux(in_aux), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we && mem_ready) begin
      got_q.push_back({mem_addr, mem_wdata});
      last_wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      last_done_cyc = cyc;
    end
  end

  // driver tasks
  task automatic do_start(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] num);
    @(posedge clk); #1;
    base_addr = base;
    num_instr = num;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] imm,
                      input logic [14:0] p1r, input logic [9:0] p2r, input logic [1:0] aux);
    bit ok = 1'b0;
    in_opcode = op; in_imm = imm; in_p1_raw = p1r; in_p2_raw = p2r; in_aux = aux;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL handshake: in_ready never high for op=%b (got %b, want 1)", op, in_ready);
    end
  endtask

  task automatic wait_done(input int start_cnt, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (done_cnt > start_cnt) ok = 1'b1;
    end
  endtask

  // tests
  task automatic test_reset;
    #12;
    vectors++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: {in_ready,mem_we,busy,done,err}=%b want 00000",
               {in_ready, mem_we, busy, done, err});
    end
    vectors++;
    if ({mem_addr, mem_wdata, err_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h err_addr=%h want 0", mem_addr, mem_wdata, err_addr);
    end
    vectors++;
    if (dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_state: got %0d want IDLE", dbg_state);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_imm10;
    bit ok;
    int d0;
    logic [EW-1:0] e, g;
    got_q.delete();
    exp_q.push_back({10'd5, 32'hC0ABC7FF});
    d0 = done_cnt;
    do_start(10'd5, 11'd1);
    send(5'b11000, 32'h000003FF, 15'h0ABC, 10'h000, 2'b01);
    wait_done(d0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL imm10_done: no done pulse (got 0, want 1)"); end
    vectors++;
    if (last_done_cyc !== last_wr_cyc + 1) begin
      miscompares++;
      $display("FAIL imm10_done_timing: done cyc %0d want %0d", last_done_cyc, last_wr_cyc + 1);
    end
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL imm10_err: got %b want 0", err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL imm10_write: none, want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL imm10_write: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_imm17_err;
    bit ok;
    int d0;
    logic [EW-1:0] e, g;
    got_q.delete();
    exp_q.push_back({10'd100, 32'h47F33BFF});
    exp_q.push_back({10'd101, 32'h00000000});
    d0 = done_cnt;
    do_start(10'd100, 11'd2);
    send(5'b01000, 32'hFFFFFFFF, 15'h0033, 10'h000, 2'b10);
    send(5'b01000, 32'h00010000, 15'h0033, 10'h000, 2'b10);
    wait_done(d0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL imm17_done: no done pulse (got 0, want 1)"); end
    vectors++;
    if ({err, err_addr} !== {1'b1, 10'd101}) begin
      miscompares++;
      $display("FAIL imm17_err: err=%b err_addr=%0d want 1/101", err, err_addr);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL imm17_write: none, want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL imm17_write: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_imm15_burst;
    bit ok;
    int d0;
    logic [EW-1:0] e, g;
    got_q.delete();
    exp_q.push_back({10'd200, 32'h24000155});
    exp_q.push_back({10'd201, 32'h23FFF155});
    exp_q.push_back({10'd202, 32'h00000000});
    exp_q.push_back({10'd203, 32'h20000155});
    exp_q.push_back({10'd500, 32'h09111E22});
    d0 = done_cnt;
    do_start(10'd200, 11'd4);
    send(5'b00100, 32'hFFFFC000, 15'h0000, 10'h155, 2'b00);
    send(5'b00100, 32'h00003FFF, 15'h0000, 10'h155, 2'b00);
    send(5'b00100, 32'h00004000, 15'h0000, 10'h155, 2'b00);
    send(5'b00100, 32'h00000000, 15'h0000, 10'h155, 2'b00);
    wait_done(d0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL imm15_done: no done pulse (got 0, want 1)"); end
    vectors++;
    if ({err, err_addr} !== {1'b1, 10'd202}) begin
      miscompares++;
      $display("FAIL imm15_err: err=%b err_addr=%0d want 1/202", err, err_addr);
    end
    d0 = done_cnt;
    do_start(10'd500, 11'd1);
    vectors++;
    if ({err, err_addr} !== '0) begin
      miscompares++;
      $display("FAIL imm15_err_clear: err=%b err_addr=%0d want 0/0", err, err_addr);
    end
    send(5'b00001, 32'h00000000, 15'h1111, 10'h222, 2'b11);
    wait_done(d0, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL imm15_write: none, want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL imm15_write: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_stall;
    int d0;
    int stalls = 0;
    bit prev_stall = 1'b0;
    logic [EW-1:0] prev_word = '0;
    logic [EW-1:0] e, g;
    got_q.delete();
    exp_q.push_back({10'd40, 32'h90001001});
    exp_q.push_back({10'd41, 32'h90001002});
    exp_q.push_back({10'd42, 32'h900013FF});
    d0 = done_cnt;
    do_start(10'd40, 11'd3);
    fork
      begin
        send(5'b10010, 32'h00000001, 15'h0001, 10'h000, 2'b00);
        send(5'b10010, 32'h00000002, 15'h0001, 10'h000, 2'b00);
        send(5'b10010, 32'h000003FF, 15'h0001, 10'h000, 2'b00);
      end
      begin
        mem_ready = 1'b1;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(posedge clk); #1; mem_ready = 1'b0;
        @(posedge clk); #1; mem_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 14; i++) begin
          @(negedge clk); #1;
          if (mem_we && !mem_ready) begin
            stalls++;
            vectors++;
            if (in_ready !== 1'b0) begin
              miscompares++;
              $display("FAIL stall_in_ready: got %b want 0", in_ready);
            end
            if (prev_stall) begin
              vectors++;
              if ({mem_addr, mem_wdata} !== prev_word) begin
                miscompares++;
                $display("FAIL stall_hold: got %h want %h", {mem_addr, mem_wdata}, prev_word);
              end
            end
            prev_stall = 1'b1;
            prev_word = {mem_addr, mem_wdata};
          end else prev_stall = 1'b0;
        end
      end
    join
    vectors++;
    if (stalls !== 2) begin miscompares++; $display("FAIL stall_count: got %0d want 2", stalls); end
    vectors++;
    if (done_cnt !== d0 + 1) begin
      miscompares++;
      $display("FAIL stall_done: got %0d pulses want 1", done_cnt - d0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL stall_write: none, want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL stall_write: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_wrap;
    bit ok;
    int d0;
    logic [EW-1:0] e, g;
    got_q.delete();
    exp_q.push_back({10'd1023, 32'h09111E22});
    exp_q.push_back({10'd0,    32'h09111C01});
    d0 = done_cnt;
    do_start(10'd1023, 11'd2);
    send(5'b00001, 32'h00000000, 15'h1111, 10'h222, 2'b11);
    send(5'b00001, 32'h00000000, 15'h1111, 10'h001, 2'b11);
    wait_done(d0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL wrap_done: no done pulse (got 0, want 1)"); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); vectors++;
      if (got_q.size() == 0) begin miscompares++; $display("FAIL wrap_write: none, want %h", e); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin miscompares++; $display("FAIL wrap_write: got %h want %h", g, e); end
      end
    end
  endtask

  task automatic test_reset_abort;
    int d0;
    logic [EW-1:0] g;
    got_q.delete();
    d0 = done_cnt;
    do_start(10'd300, 11'd4);
    send(5'b11000, 32'h000007D0, 15'h0000, 10'h000, 2'b00);
    send(5'b00001, 32'h00000000, 15'h1111, 10'h222, 2'b11);
    vectors++;
    if ({mem_we, mem_addr, err} !== {1'b1, 10'd301, 1'b1}) begin
      miscompares++;
      $display("FAIL abort_pre: we=%b addr=%0d err=%b want 1/301/1", mem_we, mem_addr, err);
    end
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      miscompares++;
      $display("FAIL abort_ctl: {in_ready,mem_we,busy,done,err}=%b want 00000",
               {in_ready, mem_we, busy, done, err});
    end
    vectors++;
    if ({mem_addr, mem_wdata, err_addr} !== '0) begin
      miscompares++;
      $display("FAIL abort_data: addr=%h wdata=%h err_addr=%h want 0", mem_addr, mem_wdata, err_addr);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    vectors++;
    if (done_cnt !== d0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0);
    end
    vectors++;
    if (got_q.size() != 1) begin
      miscompares++;
      $display("FAIL abort_writes: got %0d writes want 1", got_q.size());
    end else begin
      g = got_q.pop_front();
      if (g !== {10'd300, 32'h00000000}) begin
        miscompares++;
        $display("FAIL abort_writes: got %h want %h", g, {10'd300, 32'h00000000});
      end
    end
  endtask

  task automatic test_empty_burst;
    bit ok;
    int d0;
    got_q.delete();
    d0 = done_cnt;
    do_start(10'd77, 11'd0);
    wait_done(d0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL empty_done: no done pulse (got 0, want 1)"); end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (got_q.size() != 0 || done_cnt !== d0 + 1) begin
      miscompares++;
      $display("FAIL empty_writes: writes=%0d pulses=%0d want 0/1", got_q.size(), done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_imm10();
    test_imm17_err();
    test_imm15_burst();
    test_stall();
    test_wrap();
    test_reset_abort();
    test_empty_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
